gpgpu_multicore_ctrl: RTL and testbench

//  Parametrised multi-core launch controller for the GPGPU subsystem: OBI-slave config registers

---
 rtl/gpgpu_ctrl_pkg.sv | 24 ++
 rtl/gpgpu_ctrl_obi_regs.sv | 90 +++++++++
 rtl/gpgpu_multicore_ctrl.sv | 142 ++++++++++++++
 tb/tb_gpgpu_multicore_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gpgpu_ctrl_pkg.sv
// Shared types and register map for the multi-core launch controller.
// Word indices decode addr[4:2]; bit positions apply to CTRL and STATUS.
package gpgpu_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RESET = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_MASK   = 3'd1;
  localparam logic [2:0] REG_STATUS = 3'd2;
  localparam logic [2:0] REG_CYCLES = 3'd3;

  localparam int CTRL_START  = 0;
  localparam int CTRL_ABORT  = 1;
  localparam int CTRL_IRQ_EN = 2;

  localparam int STATUS_BUSY     = 16;
  localparam int STATUS_IRQ_PEND = 17;

endpackage

// File: rtl/gpgpu_ctrl_obi_regs.sv
// OBI slave for the launch controller: zero-wait grant, registered response,
// register storage and the START/ABORT pulses handed to the sequencing FSM.
module gpgpu_ctrl_obi_regs
  import gpgpu_ctrl_pkg::*;
#(
  parameter int NUM_CORES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req,
  output logic                 gnt,
  input  logic [31:0]          addr,
  input  logic                 we,
  input  logic [3:0]           be,
  input  logic [31:0]          wdata,
  output logic                 rvalid,
  output logic [31:0]          rdata,
  output logic                 start,
  output logic                 abort,
  output logic [NUM_CORES-1:0] core_mask,
  input  logic                 busy,
  input  logic [NUM_CORES-1:0] done,
  input  logic                 irq_set,
  input  logic [31:0]          cycles,
  output logic                 irq
);

  logic [2:0]  idx;
  logic        wr;
  logic        ctrl_wr;
  logic        irq_en;
  logic        irq_pend;
  logic [31:0] status;
  logic [31:0] rd_word;
  logic        unused_bits;

  assign gnt     = req;
  assign idx     = addr[4:2];
  assign wr      = req & we;
  assign ctrl_wr = wr && (idx == REG_CTRL);

  // ABORT in the same write suppresses START so an aborted launch never begins
  assign abort = ctrl_wr & wdata[CTRL_ABORT];
  assign start = ctrl_wr & wdata[CTRL_START] & ~wdata[CTRL_ABORT];

  always_comb begin
    status                  = '0;
    status[NUM_CORES-1:0]   = done;
    status[STATUS_BUSY]     = busy;
    status[STATUS_IRQ_PEND] = irq_pend;
  end

  always_comb begin
    rd_word = '0;
    case (idx)
      REG_CTRL:   rd_word[CTRL_IRQ_EN] = irq_en;
      REG_MASK:   rd_word[NUM_CORES-1:0] = core_mask;
      REG_STATUS: rd_word = status;
      REG_CYCLES: rd_word = cycles;
      default:    rd_word = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid    <= 1'b0;
      rdata     <= '0;
      irq_en    <= 1'b0;
      irq_pend  <= 1'b0;
      core_mask <= '0;
    end else begin
      rvalid <= req;
      rdata  <= (req && !we) ? rd_word : '0;
      if (ctrl_wr)
        irq_en <= wdata[CTRL_IRQ_EN];
      if (wr && (idx == REG_MASK) && !busy)
        core_mask <= wdata[NUM_CORES-1:0];
      // hardware set beats a coincident software clear
      if (irq_set)
        irq_pend <= 1'b1;
      else if (wr && (idx == REG_STATUS) && wdata[STATUS_IRQ_PEND])
        irq_pend <= 1'b0;
    end
  end

  assign irq = irq_pend & irq_en;

  assign unused_bits = ^{be, addr[31:5], addr[1:0], wdata};

endmodule

// File: rtl/gpgpu_multicore_ctrl.sv
// Multi-core launch controller: sequences per-core clock enables and resets,
// tracks completion on the masked cores, counts run cycles, raises an interrupt.
module gpgpu_multicore_ctrl
  import gpgpu_ctrl_pkg::*;
#(
  parameter int NUM_CORES       = 4,
  parameter int RST_HOLD_CYCLES = 4,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_i,
  output logic                 gnt_o,
  input  logic [31:0]          addr_i,
  input  logic                 we_i,
  input  logic [3:0]           be_i,
  input  logic [31:0]          wdata_i,
  output logic                 rvalid_o,
  output logic [31:0]          rdata_o,
  input  logic [NUM_CORES-1:0] core_done_i,
  output logic [NUM_CORES-1:0] clk_en_o,
  output logic [NUM_CORES-1:0] rst_n_core_o,
  output logic                 irq_o
);

  localparam int                HOLD_W    = $clog2(RST_HOLD_CYCLES + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  state_e               state;
  state_e               state_nxt;
  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 irq_set;
  logic                 launch;
  logic                 run_abort;
  logic                 all_done;
  logic [NUM_CORES-1:0] core_mask;
  logic [NUM_CORES-1:0] done_q;
  logic [NUM_CORES-1:0] done_nxt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [31:0]          cycles;

  gpgpu_ctrl_obi_regs #(
    .NUM_CORES (NUM_CORES)
  ) u_regs (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .req       (req_i),
    .gnt       (gnt_o),
    .addr      (addr_i),
    .we        (we_i),
    .be        (be_i),
    .wdata     (wdata_i),
    .rvalid    (rvalid_o),
    .rdata     (rdata_o),
    .start     (start),
    .abort     (abort),
    .core_mask (core_mask),
    .busy      (busy),
    .done      (done_q),
    .irq_set   (irq_set),
    .cycles    (cycles),
    .irq       (irq_o)
  );

  assign busy      = (state != ST_IDLE);
  assign launch    = (state == ST_IDLE) && start && (core_mask != '0);
  assign run_abort = abort && ((state == ST_RESET) || (state == ST_RUN));
  assign done_nxt  = done_q | (core_done_i & core_mask);
  assign all_done  = (done_nxt == core_mask);

  always_comb begin
    cycles                  = '0;
    cycles[CNT_WIDTH-1:0]   = cnt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (launch) state_nxt = ST_RESET;
      ST_RESET: begin
        if (run_abort)                  state_nxt = ST_IDLE;
        else if (hold_cnt == HOLD_LAST) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (run_abort)     state_nxt = ST_IDLE;
        else if (all_done) state_nxt = ST_DONE;
      end
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // An abort freezes both the counter and the completion record as they stand
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt <= '0;
      cnt      <= '0;
      done_q   <= '0;
    end else if (launch) begin
      hold_cnt <= '0;
      cnt      <= '0;
      done_q   <= '0;
    end else begin
      if (state == ST_RESET)
        hold_cnt <= hold_cnt + HOLD_W'(1);
      if ((state == ST_RUN) && !run_abort) begin
        cnt    <= sat_inc(cnt);
        done_q <= done_nxt;
      end
    end
  end

  always_comb begin
    clk_en_o     = '0;
    rst_n_core_o = '0;
    irq_set      = 1'b0;
    case (state)
      ST_RESET: clk_en_o = core_mask;
      ST_RUN: begin
        clk_en_o     = core_mask & ~done_q;
        rst_n_core_o = core_mask;
      end
      ST_DONE:  irq_set = 1'b1;
      default:  ;
    endcase
  end

endmodule

// File: tb/tb_gpgpu_multicore_ctrl.sv
// Directed bench for the launch controller; bus responses are scored against a
// queue of expected read data filled as each access is issued.
module tb_gpgpu_multicore_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [3:0]  core_done;

  logic        req_a, gnt_a, rvalid_a, irq_a;
  logic [31:0] rdata_a;
  logic [3:0]  clk_en_a, rst_core_a;
  logic        req_b, gnt_b, rvalid_b, irq_b;
  logic [31:0] rdata_b;
  logic [3:0]  clk_en_b, rst_core_b;

  int checks = 0;
  int errors = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  always #5 clk = ~clk;

  gpgpu_multicore_ctrl #(.NUM_CORES(4), .RST_HOLD_CYCLES(4), .CNT_WIDTH(32)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_a), .gnt_o(gnt_a), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_a), .rdata_o(rdata_a),
    .core_done_i(core_done), .clk_en_o(clk_en_a), .rst_n_core_o(rst_core_a), .irq_o(irq_a)
  );

  gpgpu_multicore_ctrl #(.NUM_CORES(4), .RST_HOLD_CYCLES(4), .CNT_WIDTH(4)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req_b), .gnt_o(gnt_b), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid_b), .rdata_o(rdata_b),
    .core_done_i(core_done), .clk_en_o(clk_en_b), .rst_n_core_o(rst_core_b), .irq_o(irq_b)
  );

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Response scoreboard: every rvalid pops one expected word
  always @(negedge clk) begin
    logic [31:0] e, obs;
    string       t;
    if (rvalid_a || rvalid_b) begin
      checks++;
      assert (exp_q.size() != 0) else begin
        errors++;
        $error("FAIL rsp_unexpected observed=%h expected=none", rvalid_a ? rdata_a : rdata_b);
      end
      if (exp_q.size() != 0) begin
        e   = exp_q.pop_front();
        t   = tag_q.pop_front();
        obs = rvalid_a ? rdata_a : rdata_b;
        assert (obs === e) else begin
          errors++;
          $error("FAIL %s observed=%h expected=%h", t, obs, e);
        end
      end
    end
  end

  task automatic bus(input bit sel, input bit wr, input logic [31:0] a,
                     input logic [31:0] d, input logic [31:0] e, input string t);
    exp_q.push_back(wr ? 32'h0 : e);
    tag_q.push_back(t);
    addr  = a;
    we    = wr;
    wdata = d;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    #1;
    chk(sel ? gnt_b : gnt_a, 1, {t, "_gnt"});
    @(posedge clk); #1;
    req_a = 1'b0;
    req_b = 1'b0;
    we    = 1'b0;
  endtask

  task automatic wr(input bit sel, input logic [31:0] a, input logic [31:0] d, input string t);
    bus(sel, 1'b1, a, d, 32'h0, t);
  endtask

  task automatic rd(input bit sel, input logic [31:0] a, input logic [31:0] e, input string t);
    bus(sel, 1'b0, a, 32'h0, e, t);
  endtask

  initial begin
    rst_n = 1'b0; req_a = 1'b0; req_b = 1'b0; addr = '0; we = 1'b0;
    be = 4'hF; wdata = '0; core_done = '0;
    repeat (3) @(negedge clk);
    chk(gnt_a, 0, "rst_gnt");
    chk(rvalid_a, 0, "rst_rvalid");
    chk(rdata_a, 0, "rst_rdata");
    chk(clk_en_a, 0, "rst_clk_en");
    chk(rst_core_a, 0, "rst_core_rst");
    chk(irq_a, 0, "rst_irq");
    chk({clk_en_b, rst_core_b, irq_b}, 0, "rst_b_outputs");
    rst_n = 1'b1;
    @(negedge clk);

    // Register basics and unmapped offsets
    rd(0, 32'h8, 32'h0, "status_rst");
    rd(0, 32'h1C, 32'h0, "unmapped_rd");
    @(negedge clk);
    chk(rvalid_a, 1, "rvalid_one_after");
    @(negedge clk);
    chk(rvalid_a, 0, "rvalid_single");
    wr(0, 32'h1C, 32'hFFFF_FFFF, "unmapped_wr");
    rd(0, 32'h4, 32'h0, "mask_after_unmapped");
    rd(0, 32'h0, 32'h0, "ctrl_after_unmapped");

    // Full run: cores 0 and 2, core1 done is noise on an unmasked lane
    wr(0, 32'h4, 32'h5, "mask_wr");
    rd(0, 32'h4, 32'h5, "mask_rd");
    core_done = 4'b0010;
    wr(0, 32'h0, 32'h1, "start1");
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk(rst_core_a, 4'h0, $sformatf("reset_hold_rst%0d", i));
      chk(clk_en_a, 4'h5, $sformatf("reset_hold_en%0d", i));
    end
    for (int k = 1; k <= 26; k++) begin
      @(negedge clk);
      if (k <= 25) begin
        chk(clk_en_a, (k >= 11) ? 4'h4 : 4'h5, $sformatf("run_clk_en_%0d", k));
        chk(rst_core_a, 4'h5, $sformatf("run_rst_%0d", k));
        if (k == 10) core_done[0] = 1'b1;
        if (k == 25) core_done[2] = 1'b1;
      end else begin
        chk(clk_en_a, 4'h0, "done_state_clk_en");
        chk(rst_core_a, 4'h0, "done_state_rst");
      end
    end
    @(negedge clk);
    chk(irq_a, 0, "irq_masked_by_en");
    core_done = '0;
    rd(0, 32'h8, 32'h0002_0005, "status_after_run");
    rd(0, 32'hC, 32'd25, "cycles_after_run");
    wr(0, 32'h0, 32'h4, "irq_en_on");
    @(negedge clk);
    chk(irq_a, 1, "irq_enabled");
    wr(0, 32'h8, 32'h0002_0000, "irq_w1c");
    @(negedge clk);
    chk(irq_a, 0, "irq_cleared");
    rd(0, 32'h8, 32'h0000_0005, "status_after_w1c");

    // ABORT at RUN cycle 5
    wr(0, 32'h0, 32'h5, "start2");
    repeat (9) @(negedge clk);
    chk(rst_core_a, 4'h5, "pre_abort_rst");
    wr(0, 32'h0, 32'h6, "abort");
    @(negedge clk);
    chk(clk_en_a, 0, "abort_clk_en");
    chk(rst_core_a, 0, "abort_rst");
    chk(irq_a, 0, "abort_irq");
    rd(0, 32'h8, 32'h0, "status_after_abort");
    rd(0, 32'h0, 32'h4, "ctrl_self_clear");

    // START+ABORT together never launches
    wr(0, 32'h0, 32'h7, "start_abort");
    @(negedge clk);
    chk(clk_en_a, 0, "start_abort_clk_en");
    rd(0, 32'h8, 32'h0, "start_abort_status");

    // START with an empty mask is ignored
    wr(0, 32'h4, 32'h0, "mask_zero");
    wr(0, 32'h0, 32'h5, "start_mask0");
    @(negedge clk);
    chk(clk_en_a, 0, "mask0_clk_en");
    rd(0, 32'h8, 32'h0, "mask0_status");

    // Writes while busy: MASK and a second START ignored
    wr(0, 32'h4, 32'h5, "mask_wr3");
    wr(0, 32'h0, 32'h5, "start3");
    wr(0, 32'h4, 32'hF, "mask_busy_wr");
    rd(0, 32'h4, 32'h5, "mask_busy_rd");
    rd(0, 32'h8, 32'h0001_0000, "status_busy");
    wr(0, 32'h0, 32'h5, "start_busy");
    @(negedge clk);
    chk(clk_en_a, 4'h5, "busy_run_clk_en");
    chk(rst_core_a, 4'h5, "busy_run_rst");
    wr(0, 32'h0, 32'h6, "abort3");
    @(negedge clk);
    chk(clk_en_a, 0, "abort3_clk_en");

    // W1C of IRQ_PEND in the same cycle the DONE state sets it
    wr(0, 32'h4, 32'h1, "mask_core0");
    wr(0, 32'h0, 32'h5, "start4");
    repeat (5) @(negedge clk);
    core_done = 4'b0001;
    @(negedge clk);
    chk(rst_core_a, 0, "done4_rst");
    wr(0, 32'h8, 32'h0002_0000, "w1c_coincident");
    core_done = '0;
    @(negedge clk);
    chk(irq_a, 1, "irq_set_wins");
    rd(0, 32'h8, 32'h0002_0001, "status_set_wins");
    rd(0, 32'hC, 32'd1, "cycles_short_run");

    // Asynchronous reset in the middle of a run
    wr(0, 32'h0, 32'h5, "start5");
    repeat (6) @(negedge clk);
    chk(rst_core_a, 4'h1, "pre_async_rst");
    #2 rst_n = 1'b0;
    #1;
    chk(clk_en_a, 0, "async_clk_en");
    chk(rst_core_a, 0, "async_rst_core");
    chk(irq_a, 0, "async_irq");
    chk(rvalid_a, 0, "async_rvalid");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(0, 32'h8, 32'h0, "status_after_async");
    rd(0, 32'h4, 32'h0, "mask_after_async");

    // Counter saturation on the narrow-counter instance
    wr(1, 32'h4, 32'h1, "b_mask");
    wr(1, 32'h0, 32'h1, "b_start");
    repeat (24) @(negedge clk);
    chk(rst_core_b, 4'h1, "b_run_rst");
    core_done = 4'b0001;
    repeat (2) @(negedge clk);
    core_done = '0;
    rd(1, 32'hC, 32'h0000_000F, "b_cycles_sat");
    rd(1, 32'h8, 32'h0002_0001, "b_status");

    repeat (3) @(negedge clk);
    chk(exp_q.size(), 0, "sb_drain");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
